// File: rtl/risky2_ctrl_pkg.sv
// risky2_ctrl_pkg: controller state encoding and default timing parameters
package risky2_ctrl_pkg;
  typedef enum logic [2:0] {RUN, FLUSH, UART_WAIT, DRAIN, HALTED} ctrl_state_t;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int CNT_W = 8;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: event counter that either wraps or sticks at all-ones
module perf_counter #(
  parameter int WIDTH = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  // count one per asserted inc; saturating instances hold at the maximum
  always_ff @(posedge clk or negedge rstd)
    if (!rstd) count <= '0;
    else if (inc && !(SATURATE && (&count))) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush/freeze/halt sequencing for the core pipeline
module pipeline_controller import risky2_ctrl_pkg::*; #(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic        is_data_hazard,
  input  logic        redirect_valid,
  input  logic        is_halt,
  input  logic        uart_req,
  input  logic        uart_busy,
  output logic        pc_we,
  output logic        fd_stall,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        pipe_freeze,
  output logic        uart_we,
  output logic        halted,
  output logic [31:0] stall_cnt,
  output logic [15:0] redirect_cnt
);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  ctrl_state_t state, state_nx, ret_state, ret_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic live, redir, ustall, hz, hlt;
  logic pc_we_i, fd_stall_i, fd_flush_i, de_flush_i, freeze_i, uart_we_i;
  assign live   = state == RUN || state == FLUSH || state == DRAIN;
  assign redir  = live && redirect_valid;
  assign ustall = live && !redir && uart_req && uart_busy;
  assign hz     = state == RUN && !redir && !ustall && is_data_hazard;
  assign hlt    = state == RUN && !redir && !ustall && !hz && is_halt;
  // output decode; a pending store ahead of the halt may still write while draining
  always_comb begin
    pc_we_i    = redir || ((state == RUN || state == FLUSH) && !ustall && !hz);
    fd_stall_i = ustall || hz || state == UART_WAIT;
    fd_flush_i = redir || state == DRAIN || state == HALTED;
    de_flush_i = redir || hz;
    freeze_i   = ustall || state == UART_WAIT;
    uart_we_i  = (live && uart_req && !uart_busy) || (state == UART_WAIT && !uart_busy);
  end
  // next state; a frozen DRAIN cycle leaves the drain count untouched until the UART returns
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ret_nx   = ret_state;
    if (redir) begin
      state_nx = FLUSH;
      cnt_nx   = FLUSH_LOAD;
    end else if (ustall) begin
      state_nx = UART_WAIT;
      ret_nx   = state == DRAIN ? DRAIN : RUN;
    end else if (hlt) begin
      state_nx = DRAIN;
      cnt_nx   = DRAIN_LOAD;
    end else if (state == FLUSH || state == DRAIN) begin
      state_nx = cnt == '0 ? (state == FLUSH ? RUN : HALTED) : state;
      cnt_nx   = cnt == '0 ? cnt : cnt - 1'b1;
    end else if (state == UART_WAIT && !uart_busy) begin
      state_nx = ret_state;
    end
  end
  // state registers; reset abandons any pending wait or drain
  always_ff @(posedge clk or negedge rstd)
    if (!rstd) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= '0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      cnt       <= cnt_nx;
    end
  assign pc_we       = rstd && pc_we_i;
  assign fd_stall    = rstd && fd_stall_i;
  assign fd_flush    = rstd && fd_flush_i;
  assign de_flush    = rstd && de_flush_i;
  assign pipe_freeze = rstd && freeze_i;
  assign uart_we     = rstd && uart_we_i;
  assign halted      = rstd && state == HALTED;
  perf_counter #(.WIDTH(32), .SATURATE(1'b0)) u_stall_cnt (
    .clk(clk), .rstd(rstd), .inc(!pc_we_i && state != HALTED), .count(stall_cnt)
  );
  perf_counter #(.WIDTH(16), .SATURATE(1'b1)) u_redirect_cnt (
    .clk(clk), .rstd(rstd), .inc(redir), .count(redirect_cnt)
  );
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: scoreboard bench for the pipeline controller
module tb_pipeline_controller;
  logic clk = 1'b0;
  logic rstd = 1'b1;
  logic is_data_hazard = 1'b0, redirect_valid = 1'b0, is_halt = 1'b0, uart_req = 1'b0, uart_busy = 1'b0;
  logic pc_we, fd_stall, fd_flush, de_flush, pipe_freeze, uart_we, halted;
  logic [31:0] stall_cnt;
  logic [15:0] redirect_cnt;
  logic [6:0] ctl;
  logic [6:0] sb [$];
  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  assign ctl = {pc_we, fd_stall, fd_flush, de_flush, pipe_freeze, uart_we, halted};
  always #5 clk = ~clk;
  pipeline_controller dut (
    .clk(clk), .rstd(rstd), .is_data_hazard(is_data_hazard), .redirect_valid(redirect_valid),
    .is_halt(is_halt), .uart_req(uart_req), .uart_busy(uart_busy), .pc_we(pc_we),
    .fd_stall(fd_stall), .fd_flush(fd_flush), .de_flush(de_flush), .pipe_freeze(pipe_freeze),
    .uart_we(uart_we), .halted(halted), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );
  // inputs {redirect, uart_req, uart_busy, hazard, halt}; expected {pc_we, fd_stall, fd_flush, de_flush, freeze, uart_we, halted}
  task automatic drive(input logic [4:0] in, input logic [6:0] c);
    @(posedge clk);
    #1;
    {redirect_valid, uart_req, uart_busy, is_data_hazard, is_halt} = in;
    sb.push_back(c);
    if (!c[6] && !c[0]) exp_stall++;
  endtask
  task automatic do_reset;
    {redirect_valid, uart_req, uart_busy, is_data_hazard, is_halt} = '0;
    rstd = 1'b0;
    exp_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstd = 1'b1;
  endtask
  task automatic test_reset;
    #1;
    {redirect_valid, is_data_hazard} = 2'b11;
    rstd = 1'b0;
    #1;
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, 7'b0); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    checks++;
    if (redirect_cnt !== 16'd0) begin errors++; $display("FAIL reset_redir got %0d want 0", redirect_cnt); end
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL reset_hold got %b want %b", ctl, 7'b0); end
    {redirect_valid, is_data_hazard} = 2'b00;
    @(negedge clk);
    rstd = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b1000000) begin errors++; $display("FAIL reset_release got %b want %b", ctl, 7'b1000000); end
  endtask
  task automatic test_hazard;
    logic [11:0] t [3] = '{12'b00010_0101000, 12'b00000_1000000, 12'b00010_0101000};
    logic [6:0] e;
    foreach (t[i]) begin
      drive(t[i][11:7], t[i][6:0]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl !== e) begin errors++; $display("FAIL hazard row %0d got %b want %b", i, ctl, e); end
      if (i == 1) begin
        checks++;
        if (stall_cnt !== 32'd1) begin errors++; $display("FAIL hazard_stall_cnt got %0d want 1", stall_cnt); end
      end
    end
  endtask
  task automatic test_redirect;
    logic [11:0] t [5] = '{12'b10000_1011000, 12'b00001_1000000, 12'b00010_1000000,
                           12'b00010_0101000, 12'b00000_1000000};
    logic [6:0] e;
    foreach (t[i]) begin
      drive(t[i][11:7], t[i][6:0]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl !== e) begin errors++; $display("FAIL redirect row %0d got %b want %b", i, ctl, e); end
    end
    checks++;
    if (redirect_cnt !== 16'd1) begin errors++; $display("FAIL redirect_cnt got %0d want 1", redirect_cnt); end
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL redirect_stall got %0d want %0d", stall_cnt, exp_stall); end
  endtask
  task automatic test_uart;
    logic [11:0] t [8] = '{12'b01000_1000010, 12'b01100_0100100, 12'b01100_0100100, 12'b01100_0100100,
                           12'b01100_0100100, 12'b01100_0100100, 12'b01000_0100110, 12'b00000_1000000};
    logic [6:0] e;
    logic [31:0] base;
    base = stall_cnt;
    foreach (t[i]) begin
      drive(t[i][11:7], t[i][6:0]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl !== e) begin errors++; $display("FAIL uart row %0d got %b want %b", i, ctl, e); end
    end
    checks++;
    if (stall_cnt - base !== 32'd6) begin errors++; $display("FAIL uart_stall_delta got %0d want 6", stall_cnt - base); end
  endtask
  task automatic test_halt;
    logic [11:0] t [8] = '{12'b00001_1000000, 12'b00000_0010000, 12'b00000_0010000, 12'b00000_0010000,
                           12'b00000_0010000, 12'b00000_0010001, 12'b10000_0010001, 12'b01110_0010001};
    logic [6:0] e;
    foreach (t[i]) begin
      drive(t[i][11:7], t[i][6:0]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl !== e) begin errors++; $display("FAIL halt row %0d got %b want %b", i, ctl, e); end
    end
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL halt_stall got %0d want %0d", stall_cnt, exp_stall); end
    checks++;
    if (redirect_cnt !== 16'd1) begin errors++; $display("FAIL halt_redir got %0d want 1", redirect_cnt); end
  endtask
  task automatic test_drain_uart;
    logic [11:0] t [9] = '{12'b00001_1000000, 12'b00000_0010000, 12'b01100_0110100, 12'b01100_0100100,
                           12'b01000_0100110, 12'b00000_0010000, 12'b00000_0010000, 12'b00000_0010000,
                           12'b00000_0010001};
    logic [6:0] e;
    do_reset();
    foreach (t[i]) begin
      drive(t[i][11:7], t[i][6:0]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl !== e) begin errors++; $display("FAIL drain_uart row %0d got %b want %b", i, ctl, e); end
    end
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL drain_uart_stall got %0d want %0d", stall_cnt, exp_stall); end
  endtask
  task automatic test_halt_cancel;
    logic [11:0] t [9] = '{12'b00001_1000000, 12'b00000_0010000, 12'b10000_1011000, 12'b00010_1000000,
                           12'b00001_1000000, 12'b00000_1000000, 12'b00000_1000000, 12'b00000_1000000,
                           12'b00000_1000000};
    logic [6:0] e;
    do_reset();
    foreach (t[i]) begin
      drive(t[i][11:7], t[i][6:0]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl !== e) begin errors++; $display("FAIL halt_cancel row %0d got %b want %b", i, ctl, e); end
    end
    checks++;
    if (redirect_cnt !== 16'd1) begin errors++; $display("FAIL halt_cancel_redir got %0d want 1", redirect_cnt); end
  endtask
  task automatic test_reset_mid;
    logic [11:0] t [2] = '{12'b01100_0100100, 12'b01100_0100100};
    logic [11:0] u [2] = '{12'b00010_0101000, 12'b00000_1000000};
    logic [6:0] e;
    do_reset();
    foreach (t[i]) begin
      drive(t[i][11:7], t[i][6:0]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl !== e) begin errors++; $display("FAIL reset_mid row %0d got %b want %b", i, ctl, e); end
    end
    uart_busy = 1'b0;
    rstd = 1'b0;
    exp_stall = 0;
    #1;
    checks++;
    if (ctl !== 7'b0) begin errors++; $display("FAIL reset_mid_abandon got %b want %b", ctl, 7'b0); end
    uart_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstd = 1'b1;
    foreach (u[i]) begin
      drive(u[i][11:7], u[i][6:0]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl !== e) begin errors++; $display("FAIL reset_mid_after row %0d got %b want %b", i, ctl, e); end
    end
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL reset_mid_stall got %0d want %0d", stall_cnt, exp_stall); end
  endtask
  task automatic test_saturate;
    do_reset();
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    checks++;
    if (redirect_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_near got %h want fffe", redirect_cnt); end
    repeat (70000 - 65534) @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (redirect_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_final got %h want ffff", redirect_cnt); end
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL sat_stall got %0d want 0", stall_cnt); end
    checks++;
    if (ctl !== 7'b1000000) begin errors++; $display("FAIL sat_ctl got %b want %b", ctl, 7'b1000000); end
  endtask
  initial begin
    test_reset();
    test_hazard();
    test_redirect();
    test_uart();
    test_halt();
    test_drain_uart();
    test_halt_cancel();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: cycles after a redirect during which wrong-path requests are ignored.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4: cycles from halt acceptance to halted.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  system clock.
REQ-005 rstd  in  1  asynchronous reset, active low.
REQ-006 is_data_hazard  in  1  the instruction decoded this cycle needs a stall.
REQ-007 redirect_valid  in  1  EX stage resolved an irregular PC this cycle.
REQ-008 is_halt  in  1  the instruction in DE is a halt.
REQ-009 uart_req  in  1  a store to the UART address is in the pre-memory stage.
REQ-010 uart_busy  in  1  the UART transmitter cannot accept a byte.
REQ-011 pc_we  out  1  PC register update enable.
REQ-012 fd_stall  out  1  hold the FD pipeline register.
REQ-013 fd_flush  out  1  replace FD contents with a bubble.
REQ-014 de_flush  out  1  replace DE contents with a bubble.
REQ-015 pipe_freeze  out  1  hold the DE, EM, PM, MW and WD registers.
REQ-016 uart_we  out  1  single-cycle UART write strobe.
REQ-017 halted  out  1  the core is halted.
REQ-018 stall_cnt  out  32  count of cycles with pc_we=0, excluding HALTED.
REQ-019 redirect_cnt  out  16  count of accepted redirects, saturating.

Function
REQ-020 States SHALL be RUN, FLUSH, UART_WAIT, DRAIN and HALTED; the state is registered and the outputs are decoded combinationally from state and inputs.
REQ-021 Input priority SHALL be redirect_valid > UART wait > is_data_hazard > is_halt.
REQ-022 RUN with no inputs asserted: pc_we=1; all stall, flush, freeze and uart_we outputs 0.
REQ-023 redirect_valid in RUN, FLUSH or DRAIN: pc_we=1, fd_flush=1, de_flush=1 in the same cycle; redirect_cnt increments (saturates at 0xFFFF); next state FLUSH; flush down-counter loaded with FLUSH_CYCLES-1.
REQ-024 FLUSH: is_data_hazard and is_halt are masked; pc_we=1; counter decrements; return to RUN the cycle after it reads 0. A new redirect_valid reloads the counter.
REQ-025 uart_req with uart_busy=0 in RUN or FLUSH: uart_we=1 in the same cycle; no stall.
REQ-026 uart_req with uart_busy=1: pc_we=0, fd_stall=1, pipe_freeze=1, uart_we=0; next state UART_WAIT; the return state (RUN or DRAIN) and drain count are saved.
REQ-027 UART_WAIT: freeze is held while uart_busy=1; in the first cycle uart_busy=0, uart_we=1 for exactly one cycle with the freeze still asserted; then return to the saved state.
REQ-028 is_data_hazard in RUN, not masked and no higher-priority event: pc_we=0, fd_stall=1, de_flush=1 for that cycle only; the state remains RUN.
REQ-029 is_halt in RUN, no higher-priority event: next state DRAIN; drain counter loaded with DRAIN_CYCLES-1.
REQ-030 DRAIN: pc_we=0, fd_flush=1; the counter decrements each unfrozen cycle; HALTED is entered the cycle after it reads 0.
REQ-031 redirect_valid in DRAIN SHALL cancel the halt (the halt was wrong-path) and act per REQ-023.
REQ-032 HALTED: halted=1, pc_we=0, fd_flush=1; all inputs ignored; only reset exits.
REQ-033 stall_cnt SHALL increment every cycle with pc_we=0 and state != HALTED, wrapping modulo 2^32.

Reset
REQ-034 While rstd=0: state RUN; counters, stall_cnt and redirect_cnt are 0; pc_we, fd_stall, fd_flush, de_flush, pipe_freeze, uart_we and halted are all 0.
REQ-035 Reset asserted mid-operation (including in UART_WAIT or DRAIN) SHALL abandon the pending action with no uart_we pulse; the first cycle after release is RUN.

Structure
REQ-036 The ctrl_state_t enum and the FLUSH_CYCLES/DRAIN_CYCLES defaults SHALL live in a shared package, risky2_ctrl_pkg.
REQ-037 The two event counters SHALL be a single sub-module, perf_counter, parameterised by width and by wrap or saturate behaviour.

Verification
REQ-038 Reset released, then is_data_hazard=1 for 1 cycle -> pc_we=0, fd_stall=1, de_flush=1 in that cycle only; stall_cnt=1.
REQ-039 redirect_valid=1 then is_halt=1 on the next cycle -> flushes asserted, halt ignored, RUN after 2 cycles, redirect_cnt=1, halted stays 0.
REQ-040 uart_req=1 with uart_busy=1 for 5 cycles, then 0 -> pipe_freeze=1 for 6 cycles, one uart_we pulse in the 6th, stall_cnt=6.
REQ-041 is_halt=1 in RUN, no other events -> halted=1 on the 5th cycle after, and remains 1 despite a later redirect_valid=1.
REQ-042 is_halt accepted, redirect_valid=1 two cycles later -> state FLUSH, halted never asserts.
REQ-043 redirect_valid pulsed 70000 times -> redirect_cnt saturates at 0xFFFF.
